fb_refill_sched: RTL and testbench

- Sequences full-frame refills of the 800x600 6-bit framebuffer BRAM through its write port A.
- Generates the pixel scan coordinates that the colour logic consumes, then emits the write enable and write address one cycle later, aligned with the registered colour.
- Accepts refill requests from the game tick (edge-detected) and from a forced-redraw strobe. Suppresses tick-driven refills while the game is frozen (game over).

---
 rtl/vga_pkg.sv | 15 +
 rtl/fb_refill_sched_scan_counter.sv | 46 ++++
 rtl/fb_refill_sched.sv | 106 ++++++++++
 tb/tb_fb_refill_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry defaults and refill-sequencer state encoding.
package vga_pkg;

    localparam int H_ACTIVE_DEFAULT = 800;
    localparam int V_ACTIVE_DEFAULT = 600;
    localparam int FB_DEPTH         = H_ACTIVE_DEFAULT * V_ACTIVE_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fb_refill_sched_scan_counter.sv
// Raster scan counter: column/row plus a running linear address, so no multiplier is needed.
module scan_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int COORD_W  = 12,
    parameter int ADDR_W   = 19
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);

    logic x_end;

    assign x_end = (x == COORD_W'(H_ACTIVE - 1));
    assign last  = x_end && (y == COORD_W'(V_ACTIVE - 1));

    // Wrapping to zero at the last pixel keeps x/y at 0 whenever the scan is idle.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clr || (en && last)) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (en) begin
            addr <= addr + 1'b1;
            if (x_end) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_refill_sched.sv
// Framebuffer refill sequencer: turns tick/force requests into full-frame raster writes on BRAM port A.
module fb_refill_sched
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int COORD_W  = 12,
    parameter int ADDR_W   = $clog2(FB_DEPTH)
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               tick_i,
    input  logic               force_i,
    input  logic               freeze_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               scan_o,
    output logic               wen_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [7:0]         frame_cnt_o
);

    state_t            state;
    logic              tick_q;
    logic              pending;
    logic              req;
    logic              start;
    logic              scan_last;
    logic [ADDR_W-1:0] scan_addr;

    assign req   = (tick_i & ~tick_q & ~freeze_i) | force_i;
    assign start = (state == ST_IDLE) && (req || pending);

    scan_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .COORD_W  (COORD_W),
        .ADDR_W   (ADDR_W)
    ) u_scan (
        .CLK   (CLK),
        .rst_n (rst_n),
        .clr   (start),
        .en    (state == ST_SCAN),
        .x     (x_o),
        .y     (y_o),
        .addr  (scan_addr),
        .last  (scan_last)
    );

    // wen_o/addr_o trail the scan by one cycle to line up with the registered colour.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tick_q      <= 1'b0;
            pending     <= 1'b0;
            scan_o      <= 1'b0;
            wen_o       <= 1'b0;
            addr_o      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            frame_cnt_o <= 8'd0;
        end else begin
            tick_q <= tick_i;
            wen_o  <= scan_o;
            done_o <= 1'b0;
            if (scan_o) begin
                addr_o <= scan_addr;
            end
            if (start) begin
                pending <= 1'b0;
            end else if (req) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SCAN;
                        scan_o <= 1'b1;
                        busy_o <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (scan_last) begin
                        state  <= ST_FLUSH;
                        scan_o <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state       <= ST_DONE;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b1;
                    frame_cnt_o <= frame_cnt_o + 8'd1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_refill_sched.sv
// Scoreboard bench for fb_refill_sched on an 8x4 frame; a timeline model predicts every scan, write and done.
module tb_fb_refill_sched;

    localparam int H       = 8;
    localparam int V       = 4;
    localparam int N       = H * V;
    localparam int COORD_W = 12;
    localparam int ADDR_W  = 19;

    logic               CLK      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               tick_i   = 1'b0;
    logic               force_i  = 1'b0;
    logic               freeze_i = 1'b0;
    logic [COORD_W-1:0] x_o;
    logic [COORD_W-1:0] y_o;
    logic               scan_o;
    logic               wen_o;
    logic [ADDR_W-1:0]  addr_o;
    logic               busy_o;
    logic               done_o;
    logic [7:0]         frame_cnt_o;

    fb_refill_sched #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .COORD_W  (COORD_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .tick_i      (tick_i),
        .force_i     (force_i),
        .freeze_i    (freeze_i),
        .x_o         (x_o),
        .y_o         (y_o),
        .scan_o      (scan_o),
        .wen_o       (wen_o),
        .addr_o      (addr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t scan_q[$];
    ev_t wen_q[$];
    ev_t done_q[$];
    int  busy_q[$];

    int cyc        = 0;
    int n_pass     = 0;
    int n_total    = 0;
    int idle_from  = 0;
    int frames     = 0;
    int last_start = 0;
    bit pend       = 1'b0;
    bit prev_tick  = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void check_output(string name, int actual, int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endfunction

    // A frame started at cycle s scans s..s+N-1, flushes at s+N, is done at s+N+1, idle from s+N+2.
    function automatic void schedule_frame(int s);
        frames++;
        last_start = s;
        idle_from  = s + N + 2;
        for (int i = 0; i < N; i++) begin
            scan_q.push_back(ev_t'{cyc: s + i, a: i % H, b: i / H});
            wen_q.push_back(ev_t'{cyc: s + 1 + i, a: i, b: 0});
        end
        done_q.push_back(ev_t'{cyc: s + N + 1, a: frames % 256, b: 0});
        busy_q.push_back(s);
    endfunction

    // Monitor: compare this cycle's outputs, then fold this cycle's inputs into the model.
    always @(negedge CLK) begin
        bit req;
        bit started;
        bit exp_v;
        if (!rst_n) begin
            scan_q.delete();
            wen_q.delete();
            done_q.delete();
            busy_q.delete();
            pend      = 1'b0;
            prev_tick = 1'b0;
            frames    = 0;
            idle_from = 0;
        end else begin
            exp_v = (scan_q.size() > 0) && (scan_q[0].cyc == cyc);
            check_output("scan_o", int'(scan_o), int'(exp_v));
            if (exp_v) begin
                check_output("x_o", int'(x_o), scan_q[0].a);
                check_output("y_o", int'(y_o), scan_q[0].b);
                void'(scan_q.pop_front());
            end else begin
                check_output("x_o_idle", int'(x_o), 0);
                check_output("y_o_idle", int'(y_o), 0);
            end

            exp_v = (wen_q.size() > 0) && (wen_q[0].cyc == cyc);
            check_output("wen_o", int'(wen_o), int'(exp_v));
            if (exp_v) begin
                check_output("addr_o", int'(addr_o), wen_q[0].a);
                void'(wen_q.pop_front());
            end

            exp_v = (done_q.size() > 0) && (done_q[0].cyc == cyc);
            check_output("done_o", int'(done_o), int'(exp_v));
            if (exp_v) begin
                check_output("frame_cnt_o", int'(frame_cnt_o), done_q[0].a);
                void'(done_q.pop_front());
            end

            while (busy_q.size() > 0 && busy_q[0] + N < cyc) void'(busy_q.pop_front());
            exp_v = (busy_q.size() > 0) && (busy_q[0] <= cyc);
            check_output("busy_o", int'(busy_o), int'(exp_v));

            req       = (tick_i && !prev_tick && !freeze_i) || force_i;
            prev_tick = tick_i;
            started   = 1'b0;
            if (pend && cyc >= idle_from) begin
                schedule_frame(cyc + 1);
                pend    = 1'b0;
                started = 1'b1;
            end
            if (req && !started) begin
                if (cyc >= idle_from) schedule_frame(cyc + 1);
                else pend = 1'b1;
            end
        end
    end

    task automatic apply_stimulus(input bit tk, input bit fc, input bit fz, input int n);
        tick_i   = tk;
        force_i  = fc;
        freeze_i = fz;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_cycle(input int t);
        while (cyc < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int budget = 0;
        while ((scan_q.size() > 0 || wen_q.size() > 0 || done_q.size() > 0 || pend) && budget < 3 * (N + 3) + 20) begin
            @(posedge CLK);
            #1;
            budget++;
        end
        if (budget >= 3 * (N + 3) + 20) check_output({name, "_timeout"}, 1, 0);
        apply_stimulus(tick_i, 1'b0, freeze_i, 2);
    endtask

    initial begin
        bit t;
        bit fz;
        repeat (3) @(posedge CLK);
        #1;
        check_output("rst_scan_o", int'(scan_o), 0);
        check_output("rst_wen_o", int'(wen_o), 0);
        check_output("rst_busy_o", int'(busy_o), 0);
        check_output("rst_done_o", int'(done_o), 0);
        check_output("rst_addr_o", int'(addr_o), 0);
        check_output("rst_x_o", int'(x_o), 0);
        check_output("rst_y_o", int'(y_o), 0);
        check_output("rst_frame_cnt_o", int'(frame_cnt_o), 0);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 2);

        // Single tick edge gives one full frame.
        apply_stimulus(1, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        wait_idle("single_tick");
        check_output("single_frame_cnt", int'(frame_cnt_o), 1);

        // Three edges during a scan coalesce into one follow-up frame.
        apply_stimulus(1, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        wait_cycle(last_start + 3);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 0, 1);
            apply_stimulus(0, 0, 0, 2);
        end
        wait_idle("coalesce");
        check_output("coalesce_frame_cnt", int'(frame_cnt_o), 3);

        // Frozen: tick edges ignored, force still honoured.
        apply_stimulus(0, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 1, 1);
            apply_stimulus(0, 0, 1, 2);
        end
        apply_stimulus(0, 0, 1, 10);
        check_output("frozen_no_scan_cnt", int'(frame_cnt_o), 3);
        apply_stimulus(0, 1, 1, 1);
        apply_stimulus(0, 0, 1, 1);
        wait_idle("frozen_force");
        check_output("frozen_force_cnt", int'(frame_cnt_o), 4);

        // Freeze raised mid-frame: frame completes, later ticks are dropped.
        apply_stimulus(0, 0, 0, 2);
        apply_stimulus(1, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        wait_cycle(last_start + 10);
        apply_stimulus(0, 0, 1, 1);
        wait_idle("freeze_mid");
        check_output("freeze_mid_cnt", int'(frame_cnt_o), 5);
        check_output("freeze_mid_addr_hold", int'(addr_o), N - 1);
        apply_stimulus(1, 0, 1, 1);
        apply_stimulus(0, 0, 1, 40);
        check_output("freeze_tick_dropped_cnt", int'(frame_cnt_o), 5);

        // Reset at pixel 17 aborts at once.
        apply_stimulus(0, 0, 0, 2);
        apply_stimulus(1, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        wait_cycle(last_start + 17);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_wen_o", int'(wen_o), 0);
        check_output("async_rst_scan_o", int'(scan_o), 0);
        check_output("async_rst_busy_o", int'(busy_o), 0);
        repeat (2) @(posedge CLK);
        #1;
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 40);
        check_output("post_rst_busy_o", int'(busy_o), 0);
        check_output("post_rst_frame_cnt", int'(frame_cnt_o), 0);

        // Random traffic against the model.
        t  = 1'b0;
        fz = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) t = ~t;
            if ($urandom_range(99) == 0) fz = ~fz;
            apply_stimulus(t, $urandom_range(49) == 0, fz, 1);
        end
        apply_stimulus(0, 0, 0, 1);
        wait_idle("random");

        // Counter wrap after 256 refills from a clean reset.
        rst_n = 1'b0;
        apply_stimulus(0, 0, 0, 2);
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 2);
        for (int i = 0; i < 255; i++) begin
            apply_stimulus(0, 1, 0, 1);
            apply_stimulus(0, 0, 0, 1);
            wait_idle("wrap");
        end
        check_output("wrap_cnt_255", int'(frame_cnt_o), 255);
        apply_stimulus(0, 1, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        wait_idle("wrap_last");
        check_output("wrap_cnt_0", int'(frame_cnt_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
